// File: rtl/wavegen_pkg.sv
// Shared wavegen definitions: default pipe/bank geometry, readback FSM encoding, bank slice helper.
package wavegen_pkg;

   localparam int unsigned DEF_WORD_W = 16;
   localparam int unsigned DEF_NWORDS = 64;
   localparam int unsigned DEF_BANK_W = DEF_WORD_W * DEF_NWORDS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } rb_state_t;

   // Word i of a default-geometry bank.
   function automatic logic [DEF_WORD_W-1:0] bank_word(input logic [DEF_BANK_W-1:0] b,
                                                       input int unsigned i);
      return b[i*DEF_WORD_W +: DEF_WORD_W];
   endfunction

endpackage

// File: rtl/param_readback_serializer_word_select.sv
// Registered NWORDS:1 word mux. An out-of-range select or clear loads zero.
module word_select #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned NWORDS = 64,
   parameter int unsigned CNT_W  = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     clear,
   input  logic [WORD_W*NWORDS-1:0] src,
   input  logic [CNT_W-1:0]         sel,
   output logic [WORD_W-1:0]        word
);

   logic [WORD_W-1:0] mux_c;

   always_comb begin
      mux_c = '0;
      for (int i = 0; i < int'(NWORDS); i++)
         if (sel == CNT_W'(i)) mux_c = src[i*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      word <= '0;
      else if (clear) word <= '0;
      else if (load)  word <= mux_c;
   end

endmodule

// File: rtl/param_readback_serializer.sv
// Parameter bank readback: snapshots a bank on capture and serves it word-by-word to a pipe-out.
// Optional macro READBACK_CHECKSUM_EN appends a mod-2^WORD_W sum word after the last bank word.
module param_readback_serializer
   import wavegen_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W,
   parameter int unsigned NWORDS = DEF_NWORDS,
   parameter int unsigned CNT_W  = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WORD_W*NWORDS-1:0] bank,
   input  logic                     capture,
   input  logic                     ep_read,
   output logic [WORD_W-1:0]        dout,
   output logic                     valid,
   output logic                     busy,
   output logic [CNT_W-1:0]         remaining,
   output logic                     underrun
);

`ifdef READBACK_CHECKSUM_EN
   localparam int unsigned TOTAL = NWORDS + 1;
`else
   localparam int unsigned TOTAL = NWORDS;
`endif

   rb_state_t                state_q, state_d;
   logic [WORD_W*NWORDS-1:0] snap_q;
   logic [CNT_W-1:0]         idx_q, idx_d, rem_q, rem_d;
   logic                     und_q, und_d;
   logic                     load, clear;
   logic [CNT_W-1:0]         sel;
   logic [WORD_W*NWORDS-1:0] src;
   logic [WORD_W-1:0]        sel_word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         rem_q   <= '0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         und_q   <= und_d;
         if (capture) snap_q <= bank;
      end
   end

   // Capture loads word 0 straight from the live bank, since the snapshot lands on the same edge.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      und_d   = und_q;
      load    = 1'b0;
      clear   = 1'b0;
      sel     = idx_q;
      src     = snap_q;
      if (capture) begin
         state_d = STREAM;
         idx_d   = '0;
         rem_d   = CNT_W'(TOTAL);
         und_d   = 1'b0;
         load    = 1'b1;
         sel     = '0;
         src     = bank;
      end else if (ep_read) begin
         if (state_q == STREAM) begin
            if (rem_q == CNT_W'(1)) begin
               state_d = DONE;
               idx_d   = '0;
               rem_d   = '0;
               clear   = 1'b1;
            end else begin
               idx_d = idx_q + CNT_W'(1);
               rem_d = rem_q - CNT_W'(1);
               load  = 1'b1;
               sel   = idx_q + CNT_W'(1);
            end
         end else begin
            und_d = 1'b1;
         end
      end
   end

   word_select #(.WORD_W(WORD_W), .NWORDS(NWORDS), .CNT_W(CNT_W)) u_word_select (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .clear (clear),
      .src   (src),
      .sel   (sel),
      .word  (sel_word)
   );

`ifdef READBACK_CHECKSUM_EN
   logic [WORD_W-1:0] sum_c, sum_q;
   logic              show_sum_q;

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(NWORDS); i++)
         sum_c = sum_c + bank[i*WORD_W +: WORD_W];
   end

   // The sum is latched at capture, well before the stream reaches the checksum slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q      <= '0;
         show_sum_q <= 1'b0;
      end else begin
         if (capture) sum_q <= sum_c;
         if (capture || clear)  show_sum_q <= 1'b0;
         else if (load)         show_sum_q <= (idx_d == CNT_W'(NWORDS));
      end
   end

   assign dout = show_sum_q ? sum_q : sel_word;
`else
   assign dout = sel_word;
`endif

   assign valid     = (state_q == STREAM);
   assign busy      = (state_q == STREAM);
   assign remaining = rem_q;
   assign underrun  = und_q;

endmodule

// File: tb/tb_param_readback_serializer.sv
// Directed self-checking bench for param_readback_serializer (honours READBACK_CHECKSUM_EN).
module tb_param_readback_serializer;
   import wavegen_pkg::*;

   localparam int W = 16;
   localparam int N = 64;
   localparam int C = 7;
`ifdef READBACK_CHECKSUM_EN
   localparam int NTOT = N + 1;
`else
   localparam int NTOT = N;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [W*N-1:0] bank;
   logic           capture, ep_read;
   logic [W-1:0]   dout;
   logic           valid, busy, underrun;
   logic [C-1:0]   remaining;

   int n_chk = 0;
   int n_err = 0;

   param_readback_serializer #(.WORD_W(W), .NWORDS(N), .CNT_W(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .bank      (bank),
      .capture   (capture),
      .ep_read   (ep_read),
      .dout      (dout),
      .valid     (valid),
      .busy      (busy),
      .remaining (remaining),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ramp(input logic [W-1:0] base);
      for (int i = 0; i < N; i++) bank[i*W +: W] = base + W'(i);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"}, 32'(valid), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " remaining"}, 32'(remaining), 32'd0);
      chk({tag, " dout"}, 32'(dout), 32'd0);
   endtask

   logic [W-1:0] exp_w;
   logic [W*N-1:0] snap;

   initial begin
      bank = '0; capture = 0; ep_read = 1; reset = 1;
      #1;
      // 1: reset with ep_read asserted
      chk_idle("reset");
      chk("reset underrun", 32'(underrun), 32'd0);
      tick(); tick();
      chk_idle("reset held");
      reset = 0; ep_read = 0;
      tick();

      // 2: full stream, ramp 0x0100+i
      set_ramp(16'h0100);
      capture = 1; tick(); capture = 0;
      chk("s2 valid", 32'(valid), 32'd1);
      chk("s2 busy", 32'(busy), 32'd1);
      ep_read = 1;
      for (int i = 0; i < NTOT; i++) begin
         // sum of 0x0100..0x013F = 0x4000 + 0x7E0
         exp_w = (i < N) ? W'(16'h0100 + i) : 16'h47E0;
         chk($sformatf("s2 dout[%0d]", i), 32'(dout), 32'(exp_w));
         chk($sformatf("s2 rem[%0d]", i), 32'(remaining), 32'(NTOT - i));
         chk($sformatf("s2 valid[%0d]", i), 32'(valid), 32'd1);
         tick();
      end
      ep_read = 0;
      chk_idle("s2 end");
      chk("s2 underrun", 32'(underrun), 32'd0);

      // 3: underrun in DONE, then in IDLE after reset; capture clears it
      ep_read = 1; tick(); ep_read = 0;
      chk("s3 underrun done", 32'(underrun), 32'd1);
      reset = 1; #1;
      chk("s3 underrun reset", 32'(underrun), 32'd0);
      reset = 0; tick();
      ep_read = 1; tick(); ep_read = 0;
      chk("s3 underrun idle", 32'(underrun), 32'd1);
      chk_idle("s3 idle");
      tick(); tick();
      chk("s3 underrun sticky", 32'(underrun), 32'd1);
      set_ramp(16'h2200);
      capture = 1; tick(); capture = 0;
      chk("s3 underrun clr", 32'(underrun), 32'd0);
      chk("s3 word0", 32'(dout), 32'h2200);
      chk("s3 rem", 32'(remaining), 32'(NTOT));

      // 4: restart mid-stream, capture beats simultaneous read
      set_ramp(16'h0100);
      capture = 1; tick(); capture = 0;
      ep_read = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("s4 word10", 32'(dout), 32'h010A);
      chk("s4 rem10", 32'(remaining), 32'(NTOT - 10));
      for (int i = 0; i < N; i++) bank[i*W +: W] = 16'hBEEF;
      capture = 1; tick(); capture = 0;
      chk("s4 dout", 32'(dout), 32'hBEEF);
      chk("s4 rem", 32'(remaining), 32'(NTOT));
      chk("s4 underrun", 32'(underrun), 32'd0);
      tick();
      chk("s4 next dout", 32'(dout), 32'hBEEF);
      chk("s4 next rem", 32'(remaining), 32'(NTOT - 1));
      ep_read = 0;

      // 5: live bank churns while reading; output follows snapshot, with a pause
      set_ramp(16'h1000);
      snap = bank;
      capture = 1; tick(); capture = 0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) bank[k*W +: W] = W'($urandom);
         chk($sformatf("s5 dout[%0d]", i), 32'(dout), 32'(bank_word(snap, i)));
         ep_read = (i != 5);
         tick();
         if (i == 5) begin
            chk("s5 pause hold", 32'(dout), 32'h1005);
            chk("s5 pause rem", 32'(remaining), 32'(NTOT - 5));
            ep_read = 1; tick();
         end
      end
      ep_read = 0;
`ifdef READBACK_CHECKSUM_EN
      chk("s5 rem tail", 32'(remaining), 32'd1);
`else
      chk_idle("s5 end");
`endif

`ifdef READBACK_CHECKSUM_EN
      // 6: checksum of 1..64 is 2080
      set_ramp(16'h0001);
      capture = 1; tick(); capture = 0;
      chk("s6 rem", 32'(remaining), 32'd65);
      ep_read = 1;
      for (int i = 0; i < N; i++) tick();
      chk("s6 sum", 32'(dout), 32'h0820);
      chk("s6 sum rem", 32'(remaining), 32'd1);
      chk("s6 sum valid", 32'(valid), 32'd1);
      tick(); ep_read = 0;
      chk_idle("s6 end");
`endif

      // async reset mid-stream
      set_ramp(16'h3000);
      capture = 1; tick(); capture = 0;
      ep_read = 1; tick(); tick(); ep_read = 0;
      chk("ar pre", 32'(dout), 32'h3002);
      #2 reset = 1; #1;
      chk_idle("ar");
      reset = 0; tick();
      chk_idle("ar after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
